// File: rtl/segment_value_sampler.sv
// Draws a uniform value inside a (possibly half-open) segment by LFSR rejection sampling
// and writes it into one slot of the assignment vector. Optional: SEGMENT_SAMPLER_WEIGHT_REJECT_EN.
module segment_value_sampler #(
    parameter int NUM_VARS    = 3,
    parameter int VAR_WIDTH   = 8,
    parameter int INDEX_WIDTH = 2,
    parameter int MAX_TRIES   = 15
) (
    input  logic                          in_clock,
    input  logic                          in_reset,
    input  logic [15:0]                   in_seed,
    input  logic                          in_seed_load,
    input  logic                          in_start,
    input  logic [VAR_WIDTH-1:0]          in_segment_start,
    input  logic [VAR_WIDTH-1:0]          in_segment_end,
    input  logic [1:0]                    in_segment_type,
    input  logic [7:0]                    in_segment_weight,
    input  logic [INDEX_WIDTH-1:0]        in_variable_index,
    input  logic [NUM_VARS*VAR_WIDTH-1:0] in_current_assignment,
    output logic [NUM_VARS*VAR_WIDTH-1:0] out_new_assignment,
    output logic [VAR_WIDTH-1:0]          out_value,
    output logic                          out_busy,
    output logic                          out_done,
    output logic                          out_accepted,
    output logic                          out_error
);
    localparam int TRY_WIDTH = $clog2(MAX_TRIES + 1);
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
    localparam logic signed [VAR_WIDTH-1:0] VALUE_MIN = {1'b1, {(VAR_WIDTH-1){1'b0}}};
    localparam logic signed [VAR_WIDTH-1:0] VALUE_MAX = {1'b0, {(VAR_WIDTH-1){1'b1}}};
    localparam logic [INDEX_WIDTH:0] NUM_VARS_LIMIT = (INDEX_WIDTH+1)'(NUM_VARS);
    localparam logic [TRY_WIDTH-1:0] TRY_LIMIT = TRY_WIDTH'(MAX_TRIES);

    typedef enum logic [2:0] {IDLE, LOAD, DRAW, CHECK, WRITE, DONE} stateType;
    stateType stateReg, stateNext;

    logic [15:0]                   lfsrReg, lfsrNext;
    logic signed [VAR_WIDTH-1:0]   startReg, endReg, loReg, valueReg;
    logic signed [VAR_WIDTH-1:0]   loComb, hiComb;
    logic signed [VAR_WIDTH:0]     spanReg, spanComb;
    logic [VAR_WIDTH-1:0]          maskReg, maskComb, candReg;
    logic [TRY_WIDTH-1:0]          triesReg;
    logic [1:0]                    typeReg;
    logic [INDEX_WIDTH-1:0]        indexReg;
    logic [NUM_VARS*VAR_WIDTH-1:0] assignReg, newAssignReg, writtenVector;
    logic                          candHit, indexValid, weightReject;
    logic                          doneReg, acceptedReg, errorReg;
    logic                          captureStart;

    // Smallest all-ones mask covering a non-negative span.
    function automatic logic [VAR_WIDTH-1:0] maskFor(input logic signed [VAR_WIDTH:0] span);
        logic [VAR_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < VAR_WIDTH; i++) begin
            if ($signed({1'b0, m}) < span) m = {m[VAR_WIDTH-2:0], 1'b1};
        end
        return m;
    endfunction

    assign lfsrNext     = {lfsrReg[14:0], lfsrReg[15] ^ lfsrReg[13] ^ lfsrReg[12] ^ lfsrReg[10]};
    assign loComb       = typeReg[0] ? startReg : VALUE_MIN;
    assign hiComb       = typeReg[1] ? endReg : VALUE_MAX;
    assign spanComb     = {hiComb[VAR_WIDTH-1], hiComb} - {loComb[VAR_WIDTH-1], loComb};
    assign maskComb     = maskFor(spanComb);
    assign candHit      = ({1'b0, candReg} <= spanReg);
    assign indexValid   = ({1'b0, indexReg} < NUM_VARS_LIMIT);
    assign captureStart = (stateReg == IDLE) && in_start && !in_seed_load;

    generate
        for (genvar gi = 0; gi < NUM_VARS; gi++) begin : gSlot
            assign writtenVector[gi*VAR_WIDTH +: VAR_WIDTH] =
                (indexReg == INDEX_WIDTH'(gi)) ? valueReg : assignReg[gi*VAR_WIDTH +: VAR_WIDTH];
        end
    endgenerate

`ifdef SEGMENT_SAMPLER_WEIGHT_REJECT_EN
    logic [7:0] weightReg;
    assign weightReject = (lfsrReg[15:8] >= weightReg);

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset)         weightReg <= '0;
        else if (captureStart) weightReg <= in_segment_weight;
    end
`else
    logic unusedWeight;
    assign unusedWeight = ^in_segment_weight;
    assign weightReject = 1'b0;
`endif

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) stateReg <= IDLE;
        else           stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (captureStart) stateNext = LOAD;
            LOAD:    stateNext = spanComb[VAR_WIDTH] ? DONE : DRAW;
            DRAW:    stateNext = CHECK;
            CHECK:   stateNext = (candHit || triesReg == TRY_LIMIT) ? WRITE : DRAW;
            WRITE:   stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        out_busy           = (stateReg != IDLE);
        out_done           = doneReg;
        out_value          = valueReg;
        out_new_assignment = newAssignReg;
        out_accepted       = acceptedReg;
        out_error          = errorReg;
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            lfsrReg      <= LFSR_DEFAULT;
            startReg     <= '0;
            endReg       <= '0;
            typeReg      <= '0;
            indexReg     <= '0;
            assignReg    <= '0;
            loReg        <= '0;
            spanReg      <= '0;
            maskReg      <= '0;
            candReg      <= '0;
            triesReg     <= '0;
            valueReg     <= '0;
            newAssignReg <= '0;
            doneReg      <= 1'b0;
            acceptedReg  <= 1'b0;
            errorReg     <= 1'b0;
        end else begin
            // Registered so the pulse lands the cycle after DONE.
            doneReg <= (stateReg == DONE);
            case (stateReg)
                IDLE: begin
                    if (in_seed_load) begin
                        lfsrReg <= (in_seed == 16'h0000) ? LFSR_DEFAULT : in_seed;
                    end else if (in_start) begin
                        startReg    <= in_segment_start;
                        endReg      <= in_segment_end;
                        typeReg     <= in_segment_type;
                        indexReg    <= in_variable_index;
                        assignReg   <= in_current_assignment;
                        acceptedReg <= 1'b0;
                        errorReg    <= 1'b0;
                    end
                end
                LOAD: begin
                    loReg    <= loComb;
                    spanReg  <= spanComb;
                    maskReg  <= maskComb;
                    triesReg <= '0;
                    if (spanComb[VAR_WIDTH]) begin
                        errorReg    <= 1'b1;
                        acceptedReg <= 1'b0;
                    end
                end
                DRAW: begin
                    lfsrReg  <= lfsrNext;
                    candReg  <= lfsrNext[VAR_WIDTH-1:0] & maskReg;
                    triesReg <= triesReg + 1'b1;
                end
                CHECK: begin
                    if (candHit) begin
                        valueReg <= loReg + candReg;
                    end else if (triesReg == TRY_LIMIT) begin
                        valueReg <= loReg;
                        errorReg <= 1'b1;
                    end
                end
                WRITE: begin
                    if (weightReject) begin
                        newAssignReg <= assignReg;
                        acceptedReg  <= 1'b0;
                        errorReg     <= 1'b0;
                    end else if (!indexValid) begin
                        newAssignReg <= assignReg;
                        acceptedReg  <= 1'b0;
                        errorReg     <= 1'b1;
                    end else begin
                        newAssignReg <= writtenVector;
                        acceptedReg  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/segment_value_sampler.md
Name: segment_value_sampler

Overview:
- Consumer end of the integer/continuous proposal path. Takes the segment chosen by the segment selector (start, end, type, weight) and the variable index that is being re-sampled.
- Draws a uniformly random value inside that segment using rejection sampling from an internal LFSR.
- Writes the drawn value into the current assignment vector and returns the updated vector to the variable chooser.

Parameters:
- NUM_VARS, 3, number of integer variables in the assignment vector.
- VAR_WIDTH, 8, signed width of one variable and of the segment bounds; legal range 2..15.
- INDEX_WIDTH, 2, width of the variable index.
- MAX_TRIES, 15, maximum LFSR draws before the sampler gives up.

Ports:
- in_clock  input  1  system clock, rising edge.
- in_reset  input  1  asynchronous, active-low reset.
- in_seed  input  16  LFSR seed.
- in_seed_load  input  1  pulse; loads in_seed into the LFSR, honoured only in IDLE.
- in_start  input  1  pulse; begins one sample, honoured only in IDLE.
- in_segment_start  input  VAR_WIDTH  signed lower bound.
- in_segment_end  input  VAR_WIDTH  signed upper bound.
- in_segment_type  input  2  bit0 = lower bound valid, bit1 = upper bound valid.
- in_segment_weight  input  8  segment weight; used only with the optional feature.
- in_variable_index  input  INDEX_WIDTH  variable to overwrite.
- in_current_assignment  input  NUM_VARS*VAR_WIDTH  variable 0 occupies the LSBs.
- out_new_assignment  output  NUM_VARS*VAR_WIDTH  registered updated vector.
- out_value  output  VAR_WIDTH  registered drawn value.
- out_busy  output  1  high in every state except IDLE.
- out_done  output  1  one-cycle pulse when the result is valid.
- out_accepted  output  1  1 when the assignment was modified; held until the next start.
- out_error  output  1  1 on an empty segment or retry exhaustion; held until the next start.

Behaviour:
- Reset (async, in_reset=0):
  - state=IDLE; LFSR=16'hACE1.
  - All outputs 0; out_new_assignment=0.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts once per DRAW cycle only.
  - A seed load of 0 is replaced by 16'hACE1.
  - If in_seed_load and in_start are both high in IDLE, the seed is loaded first and the start is ignored.
- Input capture: on in_start in IDLE, all in_segment_*, in_variable_index and in_current_assignment are registered. Inputs are don't-care afterwards.
- IDLE -> LOAD on in_start.
- LOAD (1 cycle):
  - lo = type[0] ? start : -2^(VAR_WIDTH-1).
  - hi = type[1] ? end : 2^(VAR_WIDTH-1)-1.
  - span = hi-lo, computed as a (VAR_WIDTH+1)-bit signed value.
  - mask = smallest 2^k-1 that is >= span.
  - tries = 0.
  - If span < 0: out_error=1, out_accepted=0, go to DONE.
  - Otherwise go to DRAW.
- DRAW (1 cycle):
  - Advance the LFSR.
  - cand = new LFSR[VAR_WIDTH-1:0] & mask.
  - tries++.
  - Go to CHECK.
- CHECK (1 cycle):
  - If cand <= span: out_value = lo+cand, truncated to VAR_WIDTH (no overflow is possible). Go to WRITE.
  - Else if tries == MAX_TRIES: out_value = lo, out_error=1, go to WRITE. The clamped value is still written.
  - Else go to DRAW.
- WRITE (1 cycle):
  - out_new_assignment = captured vector with slot in_variable_index replaced by out_value.
  - out_accepted=1.
  - An index >= NUM_VARS leaves the vector unchanged, with out_accepted=0 and out_error=1.
- DONE (1 cycle): out_done=1, then go to IDLE.
- Latency from the in_start edge to out_done high:
  - First-draw hit: 5 cycles.
  - Each rejection adds 2 cycles.
  - Empty segment: 2 cycles.
- Output holding: out_value, out_new_assignment, out_accepted and out_error hold until the next accepted start. At that start, out_accepted and out_error clear.
- Boundary cases:
  - span = 0: the first draw always hits; out_value = lo.
  - type 2'b00: full signed range, mask all ones, every draw hits.
- Reset mid-operation: immediate return to IDLE and all outputs cleared. No out_done is issued.

Optional Feature:
- Macro SEGMENT_SAMPLER_WEIGHT_REJECT_EN.
- With the macro defined:
  - WRITE first compares LFSR[15:8] against the captured weight.
  - If LFSR[15:8] >= weight, the proposal is rejected: vector unchanged, out_accepted=0, out_error=0. out_value still shows the drawn value.
  - Weight 255 accepts with probability 255/256; weight 0 always rejects.
  - Timing is unchanged.
- Without the macro: in_segment_weight is unused and the comparison logic is absent.

Test Plan:
- Reset, seed 16'hACE1, VAR_WIDTH=8, type=2'b11, start=5, end=5, index=1, assignment {3,7,9} -> out_done at cycle 5, out_value=5, vector {3,5,9}, out_accepted=1.
- type=2'b11, start=10, end=3 -> out_done 2 cycles after start, out_error=1, vector unchanged, out_accepted=0.
- type=2'b01, start=-20; run 200 samples -> every out_value is in [-20,127]; no out_error.
- type=2'b11, start=0, end=4 (mask 7); force rejection by seed choice; compare against a reference LFSR model -> exact value and latency 5+2*rejections match the model.
- in_reset pulled low while in DRAW -> outputs 0 immediately, no out_done; a new in_start 2 cycles after reset release completes normally.
- index=3 with NUM_VARS=3 -> out_error=1, vector equals input; with SEGMENT_SAMPLER_WEIGHT_REJECT_EN and weight=0 on a valid index -> out_accepted=0, vector unchanged.
